// File: rtl/fsqrt_r4_pkg.sv
// Shared types and default iteration counts for the radix-4 SRT square-root sequencer.
// The fp64 iteration count also covers the unused format code 2'b11.
package fsqrt_r4_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      ITER,
      POST,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      FMT_F16 = 2'b00,
      FMT_F32 = 2'b01,
      FMT_F64 = 2'b10
   } fmt_t;

   localparam int DEF_ITER_F16 = 6;
   localparam int DEF_ITER_F32 = 13;
   localparam int DEF_ITER_F64 = 27;
   localparam int DEF_CNT_W    = 5;

   function automatic int iter_num(input fmt_t fmt,
                                   input int n16 = DEF_ITER_F16,
                                   input int n32 = DEF_ITER_F32,
                                   input int n64 = DEF_ITER_F64);
      case (fmt)
         FMT_F16: return n16;
         FMT_F32: return n32;
         default: return n64;
      endcase
   endfunction

endpackage

// File: rtl/fsqrt_r4_iter_cnt.sv
// Loadable iteration down-counter; clear beats load beats decrement, and it saturates at zero.
// Single-cycle update, no backpressure.
module fsqrt_r4_iter_cnt #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   assign zero = (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && !zero) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/fsqrt_r4_ctrl.sv
// Radix-4 SRT sqrt sequencer: start -> PRE -> N x ITER -> POST -> DONE; result at N+3 (skip: 3).
// finish_valid_o holds until finish_ready_i; flush_i returns to IDLE from any state.
module fsqrt_r4_ctrl
   import fsqrt_r4_pkg::*;
#(
   parameter int ITER_F16 = DEF_ITER_F16,
   parameter int ITER_F32 = DEF_ITER_F32,
   parameter int ITER_F64 = DEF_ITER_F64,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid_i,
   output logic             start_ready_o,
   input  logic [1:0]       fmt_i,
   input  logic             skip_iter_i,
   input  logic             flush_i,
   output logic             init_en_o,
   output logic             iter_en_o,
   output logic             last_iter_o,
   output logic             post_en_o,
   output logic [CNT_W-1:0] iter_cnt_o,
   output logic             finish_valid_o,
   input  logic             finish_ready_i,
   output logic             busy_o
);

   state_t           state;
   state_t           state_nxt;
   fmt_t             fmt_q;
   logic             skip_q;
   logic             start_hs;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;

   assign start_hs     = start_valid_i && start_ready_o;
   assign cnt_load     = (state == PRE) && !skip_q;
   assign cnt_load_val = CNT_W'(iter_num(fmt_q, ITER_F16, ITER_F32, ITER_F64) - 1);

   fsqrt_r4_iter_cnt #(
      .CNT_W(CNT_W)
   ) u_iter_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush_i),
      .load     (cnt_load),
      .dec      (state == ITER),
      .load_val (cnt_load_val),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fmt_q  <= FMT_F16;
         skip_q <= 1'b0;
      end else if (start_hs) begin
         fmt_q  <= (fmt_i == 2'b11) ? FMT_F64 : fmt_t'(fmt_i);
         skip_q <= skip_iter_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_valid_i) state_nxt = PRE;
            PRE:     state_nxt = skip_q ? POST : ITER;
            ITER:    if (cnt_zero) state_nxt = POST;
            POST:    state_nxt = DONE;
            DONE:    if (finish_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      start_ready_o  = (state == IDLE) && !flush_i;
      init_en_o      = (state == PRE);
      iter_en_o      = (state == ITER);
      last_iter_o    = (state == ITER) && cnt_zero;
      post_en_o      = (state == POST);
      finish_valid_o = (state == DONE);
      iter_cnt_o     = (state == ITER) ? cnt : '0;
      busy_o         = (state != IDLE);
   end

endmodule
